// File: rtl/nqueen_pkg.sv
// Shared definitions for the N-queens solver: FSM states, mode encodings and
// the column-index width helper.
package nqueen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        BACK,
        EMIT,
        FINISH
    } state_e;

    localparam logic MODE_FIRST = 1'b0;
    localparam logic MODE_ALL   = 1'b1;

    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nq_conflict_masks.sv
// Column, diagonal and anti-diagonal occupancy masks with a combinational
// safety test for one (row, column) candidate.
module nq_conflict_masks
    import nqueen_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = cw_of(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clearAll_i,
    input  logic          setEn_i,
    input  logic          clrEn_i,
    input  logic [CW-1:0] opRow_i,
    input  logic [CW-1:0] opCol_i,
    input  logic [CW-1:0] chkRow_i,
    input  logic [CW-1:0] chkCol_i,
    output logic          safe_o
);

    localparam int DW = 2 * N - 1;
    localparam int IW = cw_of(DW);

    logic [N-1:0]  colm_q, colm_d;
    logic [DW-1:0] dg_q, dg_d;
    logic [DW-1:0] ad_q, ad_d;

    function automatic logic [IW-1:0] diagIdx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) + IW'(c);
    endfunction

    // Offset by N-1 so the anti-diagonal index never goes negative.
    function automatic logic [IW-1:0] antiIdx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) + IW'(N - 1) - IW'(c);
    endfunction

    assign safe_o = !colm_q[chkCol_i] && !dg_q[diagIdx(chkRow_i, chkCol_i)]
                    && !ad_q[antiIdx(chkRow_i, chkCol_i)];

    always_comb begin
        colm_d = colm_q;
        dg_d   = dg_q;
        ad_d   = ad_q;
        if (clearAll_i) begin
            colm_d = '0;
            dg_d   = '0;
            ad_d   = '0;
        end else if (setEn_i) begin
            colm_d[opCol_i]                   = 1'b1;
            dg_d[diagIdx(opRow_i, opCol_i)]   = 1'b1;
            ad_d[antiIdx(opRow_i, opCol_i)]   = 1'b1;
        end else if (clrEn_i) begin
            colm_d[opCol_i]                   = 1'b0;
            dg_d[diagIdx(opRow_i, opCol_i)]   = 1'b0;
            ad_d[antiIdx(opRow_i, opCol_i)]   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colm_q <= '0;
            dg_q   <= '0;
            ad_q   <= '0;
        end else begin
            colm_q <= colm_d;
            dg_q   <= dg_d;
            ad_q   <= ad_d;
        end
    end

endmodule

// File: rtl/nqueen_solver.sv
// Parametrised N-queens backtracking solver: one candidate per cycle, solutions
// streamed over valid/ready, optional enumeration of every solution.
module nqueen_solver
    import nqueen_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    output logic                  sol_valid,
    input  logic                  sol_ready,
    output logic [N*cw_of(N)-1:0] sol_col,
    output logic [CNT_W-1:0]      sol_count,
    output logic                  busy,
    output logic                  done,
    output logic                  no_answer
);

    localparam int            CW     = cw_of(N);
    localparam logic [CW-1:0] MAXIDX = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    r_q, r_d, c_q, c_d;
    logic [CW-1:0]    col_q [N];
    logic [CW-1:0]    col_d [N];
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             noAns_q, noAns_d;

    logic          safe, handshake, firstRow, lastRow, lastCol;
    logic [CW-1:0] prevCol, tailCol;
    logic          maskClear, maskSet, maskClr;
    logic [CW-1:0] opRow, opCol;

    assign firstRow  = (r_q == '0);
    assign lastRow   = (r_q == MAXIDX);
    assign lastCol   = (c_q == MAXIDX);
    assign prevCol   = col_q[r_q - CW'(1)];
    assign tailCol   = col_q[N-1];
    assign handshake = (state_q == EMIT) && sol_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = SCAN;
            SCAN: begin
                if (safe) begin
                    if (lastRow) state_d = EMIT;
                end else if (lastCol) begin
                    state_d = BACK;
                end
            end
            BACK: begin
                if (firstRow)               state_d = FINISH;
                else if (prevCol != MAXIDX) state_d = SCAN;
            end
            EMIT: begin
                if (handshake) begin
                    if (mode_q == MODE_FIRST)   state_d = FINISH;
                    else if (tailCol == MAXIDX) state_d = BACK;
                    else                        state_d = SCAN;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sol_valid = (state_q == EMIT);
        busy      = (state_q == SCAN) || (state_q == BACK) || (state_q == EMIT);
        done      = (state_q == FINISH);
        sol_count = count_q;
        no_answer = noAns_q;
        sol_col   = '0;
        if (state_q == EMIT) begin
            for (int i = 0; i < N; i++) begin
                sol_col[i*CW +: CW] = col_q[i];
            end
        end
    end

    // Mask set/clear share one address port: the three operations are exclusive by state.
    always_comb begin
        maskClear = (state_q == IDLE) && start;
        maskSet   = (state_q == SCAN) && safe;
        maskClr   = ((state_q == BACK) && !firstRow) || (handshake && (mode_q == MODE_ALL));
        opRow     = r_q;
        opCol     = c_q;
        if (state_q == BACK) begin
            opRow = r_q - CW'(1);
            opCol = prevCol;
        end else if (state_q == EMIT) begin
            opRow = MAXIDX;
            opCol = tailCol;
        end
    end

    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        col_d   = col_q;
        mode_d  = mode_q;
        count_d = count_q;
        noAns_d = noAns_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    noAns_d = 1'b0;
                    mode_d  = mode;
                end
            end
            SCAN: begin
                if (safe) begin
                    col_d[r_q] = c_q;
                    if (!lastRow) begin
                        r_d = r_q + CW'(1);
                        c_d = '0;
                    end
                end else if (!lastCol) begin
                    c_d = c_q + CW'(1);
                end
            end
            BACK: begin
                if (!firstRow) begin
                    r_d = r_q - CW'(1);
                    c_d = prevCol + CW'(1);
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
                    if ((mode_q == MODE_ALL) && (tailCol != MAXIDX)) c_d = tailCol + CW'(1);
                end
            end
            default: ;
        endcase
        // Resolve no_answer on entry to FINISH so it is already valid alongside done.
        if ((state_d == FINISH) && (state_q != FINISH)) noAns_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            c_q     <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            noAns_q <= 1'b0;
            for (int i = 0; i < N; i++) col_q[i] <= '0;
        end else begin
            r_q     <= r_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            noAns_q <= noAns_d;
            for (int i = 0; i < N; i++) col_q[i] <= col_d[i];
        end
    end

    nq_conflict_masks #(
        .N  (N),
        .CW (CW)
    ) uMasks (
        .clk        (clk),
        .reset      (reset),
        .clearAll_i (maskClear),
        .setEn_i    (maskSet),
        .clrEn_i    (maskClr),
        .opRow_i    (opRow),
        .opCol_i    (opCol),
        .chkRow_i   (r_q),
        .chkCol_i   (c_q),
        .safe_o     (safe)
    );

endmodule

// File: tb/tb_nqueen_solver.sv
// Self-checking bench for nqueen_solver; expected solutions come from a brute-force
// permutation search over the board rules.
module tb_nqueen_solver;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic start4 = 1'b0, mode4 = 1'b0, ready4 = 1'b0;
    logic valid4, busy4, done4, noAns4;
    logic [7:0]  col4;
    logic [31:0] count4;

    logic validS, busyS, doneS, noAnsS;
    logic [7:0] colS;
    logic [0:0] countS;

    logic start8 = 1'b0, mode8 = 1'b0, ready8 = 1'b0;
    logic valid8, busy8, done8, noAns8;
    logic [23:0] col8;
    logic [31:0] count8;

    logic modeAll = 1'b1, readyHi = 1'b1;
    logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
    logic valid1, valid2, valid3, busy1, busy2, busy3, done1, done2, done3;
    logic noAns1, noAns2, noAns3;
    logic [0:0] col1;
    logic [1:0] col2;
    logic [5:0] col3;
    logic [31:0] count1, count2, count3;

    nqueen_solver #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4),
        .sol_valid(valid4), .sol_ready(ready4), .sol_col(col4), .sol_count(count4),
        .busy(busy4), .done(done4), .no_answer(noAns4));

    nqueen_solver #(.N(4), .CNT_W(1)) dutS (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4),
        .sol_valid(validS), .sol_ready(ready4), .sol_col(colS), .sol_count(countS),
        .busy(busyS), .done(doneS), .no_answer(noAnsS));

    nqueen_solver #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8),
        .sol_valid(valid8), .sol_ready(ready8), .sol_col(col8), .sol_count(count8),
        .busy(busy8), .done(done8), .no_answer(noAns8));

    nqueen_solver #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(modeAll),
        .sol_valid(valid1), .sol_ready(readyHi), .sol_col(col1), .sol_count(count1),
        .busy(busy1), .done(done1), .no_answer(noAns1));

    nqueen_solver #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(modeAll),
        .sol_valid(valid2), .sol_ready(readyHi), .sol_col(col2), .sol_count(count2),
        .busy(busy2), .done(done2), .no_answer(noAns2));

    nqueen_solver #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .mode(modeAll),
        .sol_valid(valid3), .sol_ready(readyHi), .sol_col(col3), .sol_count(count3),
        .busy(busy3), .done(done3), .no_answer(noAns3));

    // Solutions are kept as 4 bits per row regardless of board size.
    logic [63:0] refQ[$];
    logic [63:0] ref4[$];
    logic [63:0] ref8[$];
    logic [63:0] got4[$];

    // Lexicographic walk over all permutations keeps only those with no shared diagonal.
    function automatic void enumerateSolutions(input int n);
        int p[16];
        int i, j, t, a, b;
        bit ok;
        logic [63:0] s;
        refQ.delete();
        for (int k = 0; k < 16; k++) p[k] = k;
        while (1) begin
            ok = 1'b1;
            for (int x = 0; x < n; x++)
                for (int y = x + 1; y < n; y++)
                    if ((p[x] - p[y] == y - x) || (p[y] - p[x] == y - x)) ok = 1'b0;
            if (ok) begin
                s = '0;
                for (int k = 0; k < n; k++) s[k*4 +: 4] = 4'(p[k]);
                refQ.push_back(s);
            end
            i = n - 2;
            while (i >= 0 && p[i] > p[i+1]) i--;
            if (i < 0) break;
            j = n - 1;
            while (p[j] < p[i]) j--;
            t = p[i]; p[i] = p[j]; p[j] = t;
            a = i + 1;
            b = n - 1;
            while (a < b) begin
                t = p[a]; p[a] = p[b]; p[b] = t;
                a++; b--;
            end
        end
    endfunction

    function automatic logic [63:0] unpackSol(input logic [47:0] flat, input int n, input int cw);
        logic [63:0] s;
        s = '0;
        for (int r = 0; r < n; r++)
            for (int b = 0; b < cw; b++)
                s[r*4 + b] = flat[r*cw + b];
        return s;
    endfunction

    // Starts dut4 and records every handshake until done or the budget runs out.
    task automatic run4(input logic m, input int budget, output bit finished, output int nValid,
                        output int nDone, output logic busyRise, output logic busyAtDone);
        got4.delete();
        nValid = 0;
        nDone = 0;
        finished = 1'b0;
        busyAtDone = 1'b1;
        @(posedge clk); #1;
        mode4 = m;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk);
        busyRise = busy4;
        for (int i = 0; i < budget && !finished; i++) begin
            if (valid4) begin
                nValid++;
                if (ready4) got4.push_back(unpackSol({40'd0, col4}, 4, 2));
            end
            if (done4) begin
                nDone++;
                finished = 1'b1;
                busyAtDone = busy4;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        if (done4) nDone++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid4, busy4, done4, noAns4, col4, count4} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_n4_outputs got %h expected 0", {valid4, busy4, done4, noAns4, col4, count4});
        end
        checks++;
        if ({valid8, busy8, done8, noAns8, col8, count8} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_n8_outputs got %h expected 0", {valid8, busy8, done8, noAns8, col8, count8});
        end
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid4, busy4, done4, noAns4} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got %b expected 0000", {valid4, busy4, done4, noAns4});
        end
    endtask

    task automatic test_n4_first;
        bit fin;
        int nValid, nDone;
        logic busyRise, busyAtDone;
        ready4 = 1'b1;
        run4(1'b0, 2000, fin, nValid, nDone, busyRise, busyAtDone);
        checks++;
        if (fin !== 1'b1) begin errors++; $display("[TB] FAIL n4_first_timeout got %b expected 1", fin); end
        checks++;
        if (busyRise !== 1'b1) begin errors++; $display("[TB] FAIL n4_busy_rise got %b expected 1", busyRise); end
        checks++;
        if (nValid != 1) begin errors++; $display("[TB] FAIL n4_first_valid_cycles got %0d expected 1", nValid); end
        checks++;
        if (got4.size() != 1 || got4[0] !== 64'h2031) begin
            errors++;
            $display("[TB] FAIL n4_first_sol got %0d sols first %h expected 1 sol 2031", got4.size(),
                     (got4.size() > 0) ? got4[0] : 64'hx);
        end
        checks++;
        if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL n4_busy_at_done got %b expected 0", busyAtDone); end
        checks++;
        if (nDone != 1) begin errors++; $display("[TB] FAIL n4_done_pulses got %0d expected 1", nDone); end
        checks++;
        if (count4 !== 32'd1) begin errors++; $display("[TB] FAIL n4_first_count got %0d expected 1", count4); end
        checks++;
        if (noAns4 !== 1'b0) begin errors++; $display("[TB] FAIL n4_first_noans got %b expected 0", noAns4); end
    endtask

    task automatic test_n4_all;
        bit fin;
        int nValid, nDone;
        logic busyRise, busyAtDone;
        ready4 = 1'b1;
        run4(1'b1, 2000, fin, nValid, nDone, busyRise, busyAtDone);
        checks++;
        if (fin !== 1'b1) begin errors++; $display("[TB] FAIL n4_all_timeout got %b expected 1", fin); end
        checks++;
        if (got4.size() != ref4.size()) begin
            errors++;
            $display("[TB] FAIL n4_all_nsol got %0d expected %0d", got4.size(), ref4.size());
        end
        for (int i = 0; i < got4.size() && i < ref4.size(); i++) begin
            checks++;
            if (got4[i] !== ref4[i]) begin
                errors++;
                $display("[TB] FAIL n4_all_sol%0d got %h expected %h", i, got4[i], ref4[i]);
            end
        end
        checks++;
        if (nValid != ref4.size()) begin errors++; $display("[TB] FAIL n4_all_valid_cycles got %0d expected %0d", nValid, ref4.size()); end
        checks++;
        if (count4 !== 32'(ref4.size())) begin errors++; $display("[TB] FAIL n4_all_count got %0d expected %0d", count4, ref4.size()); end
        checks++;
        if (countS !== 1'b1) begin errors++; $display("[TB] FAIL n4_count_saturate got %0d expected 1", countS); end
        checks++;
        if (noAns4 !== 1'b0) begin errors++; $display("[TB] FAIL n4_all_noans got %b expected 0", noAns4); end
    endtask

    task automatic test_n8_random_ready;
        bit fin;
        int idx;
        bit stalled;
        logic [23:0] heldCol, firstCol;
        logic [63:0] s;
        fin = 1'b0;
        idx = 0;
        stalled = 1'b0;
        heldCol = '0;
        firstCol = '0;
        @(posedge clk); #1;
        mode8 = 1'b1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        ready8 = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < 60000 && !fin; i++) begin
            if (valid8) begin
                if (stalled) begin
                    checks++;
                    if (col8 !== heldCol) begin
                        errors++;
                        $display("[TB] FAIL n8_stall_stable got %h expected %h", col8, heldCol);
                    end
                end
                if (ready8) begin
                    s = unpackSol({24'd0, col8}, 8, 3);
                    if (idx == 0) firstCol = col8;
                    checks++;
                    if (idx >= ref8.size() || s !== ref8[idx]) begin
                        errors++;
                        $display("[TB] FAIL n8_sol%0d got %h expected %h", idx, s,
                                 (idx < ref8.size()) ? ref8[idx] : 64'hx);
                    end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    heldCol = col8;
                end
            end
            if (done8) begin
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                ready8 = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        ready8 = 1'b0;
        checks++;
        if (fin !== 1'b1) begin errors++; $display("[TB] FAIL n8_timeout got %b expected 1", fin); end
        checks++;
        if (idx != 92) begin errors++; $display("[TB] FAIL n8_handshakes got %0d expected 92", idx); end
        checks++;
        if (count8 !== 32'd92) begin errors++; $display("[TB] FAIL n8_count got %0d expected 92", count8); end
        checks++;
        if (firstCol !== {3'd3, 3'd1, 3'd6, 3'd2, 3'd5, 3'd7, 3'd4, 3'd0}) begin
            errors++;
            $display("[TB] FAIL n8_first_sol got %h expected %h", firstCol, {3'd3, 3'd1, 3'd6, 3'd2, 3'd5, 3'd7, 3'd4, 3'd0});
        end
        checks++;
        if (noAns8 !== 1'b0) begin errors++; $display("[TB] FAIL n8_noans got %b expected 0", noAns8); end
    endtask

    task automatic test_small_boards;
        int v1, v2, v3;
        bit d1, d2, d3;
        logic [0:0] seen1;
        logic na2, na3;
        v1 = 0; v2 = 0; v3 = 0;
        d1 = 0; d2 = 0; d3 = 0;
        seen1 = 1'bx;
        na2 = 1'b0; na3 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1; start2 = 1'b1; start3 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        for (int i = 0; i < 500 && !(d1 && d2 && d3); i++) begin
            @(negedge clk);
            if (valid1) begin v1++; seen1 = col1; end
            if (valid2) v2++;
            if (valid3) v3++;
            if (done1) d1 = 1'b1;
            if (done2) begin d2 = 1'b1; na2 = noAns2; end
            if (done3) begin d3 = 1'b1; na3 = noAns3; end
        end
        checks++;
        if ({d1, d2, d3} !== 3'b111) begin errors++; $display("[TB] FAIL small_done got %b expected 111", {d1, d2, d3}); end
        checks++;
        if (v2 != 0 || v3 != 0) begin errors++; $display("[TB] FAIL small_no_valid got %0d/%0d expected 0/0", v2, v3); end
        checks++;
        if ({na2, na3} !== 2'b11) begin errors++; $display("[TB] FAIL small_noans_at_done got %b expected 11", {na2, na3}); end
        checks++;
        if (count2 !== 32'd0 || count3 !== 32'd0) begin errors++; $display("[TB] FAIL small_count got %0d/%0d expected 0/0", count2, count3); end
        checks++;
        if (v1 != 1 || seen1 !== 1'b0) begin errors++; $display("[TB] FAIL n1_solution got %0d sols col %b expected 1 sol col 0", v1, seen1); end
        checks++;
        if (count1 !== 32'd1 || noAns1 !== 1'b0) begin errors++; $display("[TB] FAIL n1_count got %0d noans %b expected 1 noans 0", count1, noAns1); end
        repeat (3) @(negedge clk);
        checks++;
        if ({noAns2, noAns3} !== 2'b11) begin errors++; $display("[TB] FAIL small_noans_held got %b expected 11", {noAns2, noAns3}); end
    endtask

    task automatic test_reset_mid_emit;
        bit fin, hit;
        int nValid, nDone;
        logic busyRise, busyAtDone;
        logic [7:0] firstSeen;
        hit = 1'b0;
        firstSeen = '0;
        ready4 = 1'b0;
        @(posedge clk); #1;
        mode4 = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (valid4) begin hit = 1'b1; firstSeen = col4; end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!hit || valid4 !== 1'b1 || col4 !== firstSeen) begin
            errors++;
            $display("[TB] FAIL emit_hold got valid %b col %h expected valid 1 col %h", valid4, col4, firstSeen);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({valid4, busy4, done4, noAns4, col4, count4} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_emit got %h expected 0", {valid4, busy4, done4, noAns4, col4, count4});
        end
        @(negedge clk);
        #2 reset = 1'b0;
        ready4 = 1'b1;
        run4(1'b0, 2000, fin, nValid, nDone, busyRise, busyAtDone);
        checks++;
        if (!fin || got4.size() != 1 || got4[0] !== ref4[0]) begin
            errors++;
            $display("[TB] FAIL restart_after_reset got %0d sols first %h expected 1 sol %h", got4.size(),
                     (got4.size() > 0) ? got4[0] : 64'hx, ref4[0]);
        end
    endtask

    task automatic test_start_held;
        bit fin;
        int nDone;
        ready4 = 1'b1;
        fin = 1'b0;
        nDone = 0;
        @(posedge clk); #1;
        mode4 = 1'b0;
        start4 = 1'b1;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk);
            if (done4) begin
                fin = 1'b1;
                checks++;
                if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL held_busy_at_done got %b expected 0", busy4); end
            end
        end
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL start_in_finish_ignored got busy %b expected 0", busy4); end
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("[TB] FAIL start_first_idle_accepted got busy %b expected 1", busy4); end
        start4 = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk);
            if (done4) begin fin = 1'b1; nDone++; end
        end
        repeat (6) begin
            @(negedge clk);
            if (done4 || busy4) nDone++;
        end
        checks++;
        if (!fin || nDone != 1) begin errors++; $display("[TB] FAIL held_done_once got %0d pulses expected 1", nDone); end
        checks++;
        if (count4 !== 32'd1) begin errors++; $display("[TB] FAIL held_count got %0d expected 1", count4); end
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        enumerateSolutions(4);
        ref4 = refQ;
        enumerateSolutions(8);
        ref8 = refQ;
        test_reset();
        test_n4_first();
        test_n4_all();
        test_n8_random_ready();
        test_small_boards();
        test_reset_mid_emit();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
